frame_sync_align: RTL and testbench



---
 rtl/frame_sync_align_if.sv | 27 ++
 rtl/frame_sync_align.sv | 190 +++++++++++++++++++
 tb/tb_frame_sync_align.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sync_align_if.sv
// Word-stream bundle for the frame synchroniser.
// master = stream source/consumer side, slave = synchroniser side.
interface frame_sync_align_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic              din_vld;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              dout_sof;
  logic              dout_eof;
  logic              locked;
  logic              frame_err;
  logic [15:0]       frame_cnt;

  modport master (
    output din, din_vld,
    input  dout, dout_vld, dout_sof, dout_eof,
    input  locked, frame_err, frame_cnt
  );

  modport slave (
    input  din, din_vld,
    output dout, dout_vld, dout_sof, dout_eof,
    output locked, frame_err, frame_cnt
  );
endinterface

// File: rtl/frame_sync_align.sv
// Frame synchroniser: header hunt, lock verification,
// flywheel over header misses and payload forwarding.
module frame_sync_align #(
  parameter int DATA_W      = 8,
  parameter int HDR_LEN     = 2,
  parameter logic [DATA_W*HDR_LEN-1:0] HDR_PATTERN = 16'hEE33,
  parameter int PAYLOAD_LEN = 124,
  parameter int VERIFY_CNT  = 2,
  parameter int MISS_LIMIT  = 2
) (
  input logic               clk,
  input logic               rst,
  frame_sync_align_if.slave bus
);
  localparam int WW = DATA_W * HDR_LEN;
  localparam int PW = $clog2(PAYLOAD_LEN + 1);
  localparam int HW = $clog2(HDR_LEN + 1);
  localparam int GW = $clog2(VERIFY_CNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  state_t            state_q, state_n;
  logic [WW-1:0]     win_q, win_n;
  logic [PW-1:0]     pay_q, pay_n;
  logic [HW-1:0]     idx_q, idx_n;
  logic [GW-1:0]     good_q, good_n;
  logic [MW-1:0]     miss_q, miss_n;
  logic              bad_q, bad_n;
  logic              fwd_q, fwd_n;
  logic              lock_q, lock_n;
  logic              err_q, err_n;
  logic [DATA_W-1:0] dout_q, dout_n;
  logic              vld_q, vld_n;
  logic              sof_q, sof_n;
  logic              eof_q, eof_n;
  logic [15:0]       fcnt_q, fcnt_n;

  logic [WW-1:0]     win_shift;
  logic [DATA_W-1:0] pat_word;
  logic              hit;
  logic              last_pay;
  logic              last_hdr;
  logic              match;
  logic              gate;
  logic [GW-1:0]     good_inc;

  assign win_shift = (win_q << DATA_W) | WW'(bus.din);
  assign hit       = (win_shift == HDR_PATTERN);
  assign pat_word  = DATA_W'(HDR_PATTERN >>
                     ((HDR_LEN - 1 - int'(idx_q)) * DATA_W));
  assign match     = (bus.din == pat_word);
  assign last_pay  = (pay_q == PW'(PAYLOAD_LEN - 1));
  assign last_hdr  = (idx_q == HW'(HDR_LEN - 1));
  assign good_inc  = (good_q < GW'(VERIFY_CNT)) ?
                     good_q + GW'(1) : good_q;

  // Next-state, counters and registered outputs
  always_comb begin
    state_n = state_q;
    win_n   = win_q;
    pay_n   = pay_q;
    idx_n   = idx_q;
    good_n  = good_q;
    miss_n  = miss_q;
    bad_n   = bad_q;
    fwd_n   = fwd_q;
    lock_n  = lock_q;
    err_n   = 1'b0;
    dout_n  = dout_q;
    vld_n   = 1'b0;
    sof_n   = 1'b0;
    eof_n   = 1'b0;
    fcnt_n  = fcnt_q;
    gate    = fwd_q;
    if (bus.din_vld) begin
      win_n = win_shift;
      unique case (state_q)
        HUNT: begin
          if (hit) begin
            state_n = PAYLOAD;
            pay_n   = '0;
            good_n  = GW'(1);
            miss_n  = '0;
            lock_n  = (GW'(1) == GW'(VERIFY_CNT));
          end
        end
        PAYLOAD: begin
          gate  = (pay_q == '0) ? lock_q : fwd_q;
          fwd_n = gate;
          if (gate) begin
            dout_n = bus.din;
            vld_n  = 1'b1;
            sof_n  = (pay_q == '0);
            eof_n  = last_pay;
            if (last_pay) fcnt_n = fcnt_q + 16'd1;
          end
          if (last_pay) begin
            state_n = CHECK;
            pay_n   = '0;
            idx_n   = '0;
            bad_n   = 1'b0;
          end else begin
            pay_n = pay_q + PW'(1);
          end
        end
        CHECK: begin
          if (!bad_q && !match) begin
            err_n = 1'b1;
            if (!lock_q) begin
              good_n  = '0;
              state_n = HUNT;
            end else if (miss_q + MW'(1) == MW'(MISS_LIMIT)) begin
              miss_n  = '0;
              lock_n  = 1'b0;
              good_n  = '0;
              state_n = HUNT;
            end else begin
              miss_n = miss_q + MW'(1);
              bad_n  = 1'b1;
              if (last_hdr) begin
                state_n = PAYLOAD;
                pay_n   = '0;
              end else begin
                idx_n = idx_q + HW'(1);
              end
            end
          end else if (last_hdr) begin
            if (!bad_q) begin
              good_n = good_inc;
              miss_n = '0;
              if (good_inc == GW'(VERIFY_CNT)) lock_n = 1'b1;
            end
            bad_n   = 1'b0;
            state_n = PAYLOAD;
            pay_n   = '0;
          end else begin
            idx_n = idx_q + HW'(1);
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      win_q   <= '0;
      pay_q   <= '0;
      idx_q   <= '0;
      good_q  <= '0;
      miss_q  <= '0;
      bad_q   <= 1'b0;
      fwd_q   <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_n;
      win_q   <= win_n;
      pay_q   <= pay_n;
      idx_q   <= idx_n;
      good_q  <= good_n;
      miss_q  <= miss_n;
      bad_q   <= bad_n;
      fwd_q   <= fwd_n;
      lock_q  <= lock_n;
      err_q   <= err_n;
      dout_q  <= dout_n;
      vld_q   <= vld_n;
      sof_q   <= sof_n;
      eof_q   <= eof_n;
      fcnt_q  <= fcnt_n;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = vld_q;
  assign bus.dout_sof  = sof_q;
  assign bus.dout_eof  = eof_q;
  assign bus.locked    = lock_q;
  assign bus.frame_err = err_q;
  assign bus.frame_cnt = fcnt_q;
endmodule

// File: tb/tb_frame_sync_align.sv
// Directed bench for frame_sync_align: default 8-bit
// instance plus a 16-bit / 4-word-header instance.
module tb_frame_sync_align;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_sync_align_if #(.DATA_W(8))  bus ();
  frame_sync_align_if #(.DATA_W(16)) bus2 ();

  frame_sync_align dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  frame_sync_align #(
    .DATA_W      (16),
    .HDR_LEN     (4),
    .HDR_PATTERN (64'hF0F0_1234_ABCD_5A5A),
    .PAYLOAD_LEN (8),
    .VERIFY_CNT  (1),
    .MISS_LIMIT  (2)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] pay [124];

  int nvld = 0, nsof = 0, neof = 0, nerr = 0;
  int seq_bad = 0, late_vld = 0, idx = 0;
  logic [7:0] sof_dat = 8'h00, eof_dat = 8'h00;
  logic acc_prev = 1'b0;

  int nvld2 = 0, seq2_bad = 0, idx2 = 0;
  logic [15:0] sof2_dat = 16'h0, eof2_dat = 16'h0;

  always @(posedge clk) acc_prev <= bus.din_vld;

  // Output monitor for the 8-bit instance
  always @(negedge clk) begin
    if (bus.dout_vld) begin
      if (bus.dout_sof) begin
        idx = 0;
        nsof++;
        sof_dat = bus.dout;
      end
      if (idx >= 124 || bus.dout !== pay[idx]) seq_bad++;
      idx++;
      nvld++;
      if (bus.dout_eof) begin
        neof++;
        eof_dat = bus.dout;
        if (idx != 124) seq_bad++;
      end
      if (!acc_prev) late_vld++;
    end
    if (bus.frame_err) nerr++;
  end

  // Output monitor for the 16-bit instance
  always @(negedge clk) begin
    if (bus2.dout_vld) begin
      if (bus2.dout_sof) begin
        idx2 = 0;
        sof2_dat = bus2.dout;
      end
      if (bus2.dout !== 16'hA000 + 16'(idx2)) seq2_bad++;
      if (bus2.dout_eof) eof2_dat = bus2.dout;
      idx2++;
      nvld2++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] w, input bit rnd);
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        bus.din     = 8'hEE;
        bus.din_vld = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.din     = w;
    bus.din_vld = 1'b1;
    @(posedge clk); #1;
    bus.din_vld = 1'b0;
  endtask

  task automatic put2(input logic [15:0] w);
    bus2.din     = w;
    bus2.din_vld = 1'b1;
    @(posedge clk); #1;
    bus2.din_vld = 1'b0;
  endtask

  task automatic hdr(input bit rnd);
    put(8'hEE, rnd);
    put(8'h33, rnd);
  endtask

  task automatic payload(input bit rnd);
    for (int i = 0; i < 124; i++) put(pay[i], rnd);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  int e0, v0, s0, f0;

  initial begin
    for (int i = 0; i < 124; i++) pay[i] = 8'(i);
    rst          = 1'b1;
    bus.din      = '0;
    bus.din_vld  = 1'b0;
    bus2.din     = '0;
    bus2.din_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout",  32'(bus.dout), 32'h0);
    chk("rst_vld",   32'(bus.dout_vld), 32'h0);
    chk("rst_sof",   32'(bus.dout_sof), 32'h0);
    chk("rst_eof",   32'(bus.dout_eof), 32'h0);
    chk("rst_lock",  32'(bus.locked), 32'h0);
    chk("rst_err",   32'(bus.frame_err), 32'h0);
    chk("rst_fcnt",  32'(bus.frame_cnt), 32'h0);
    rst = 1'b0;

    // 1: acquire lock, second frame forwarded
    hdr(0);
    payload(0);
    chk("t1_nolock_f1", 32'(bus.locked), 32'h0);
    chk("t1_no_fwd_f1", 32'(nvld), 32'd0);
    put(8'hEE, 0);
    chk("t1_lock_pre", 32'(bus.locked), 32'h0);
    put(8'h33, 0);
    chk("t1_lock", 32'(bus.locked), 32'h1);
    payload(0);
    settle();
    chk("t1_nvld", 32'(nvld), 32'd124);
    chk("t1_nsof", 32'(nsof), 32'd1);
    chk("t1_neof", 32'(neof), 32'd1);
    chk("t1_sof_dat", 32'(sof_dat), 32'h00);
    chk("t1_eof_dat", 32'(eof_dat), 32'h7B);
    chk("t1_fcnt", 32'(bus.frame_cnt), 32'd1);
    chk("t1_seq", 32'(seq_bad), 32'd0);

    // 2: single bad header is flywheeled
    e0 = nerr;
    put(8'hEE, 0);
    put(8'h34, 0);
    chk("t2_err_pulse", 32'(bus.frame_err), 32'h1);
    payload(0);
    settle();
    chk("t2_nerr", 32'(nerr), 32'(e0 + 1));
    chk("t2_lock", 32'(bus.locked), 32'h1);
    chk("t2_fcnt", 32'(bus.frame_cnt), 32'd2);
    chk("t2_nvld", 32'(nvld), 32'd248);

    // 3: two consecutive bad headers drop lock
    hdr(0);
    payload(0);
    put(8'h00, 0);
    put(8'h00, 0);
    payload(0);
    settle();
    chk("t3_fly_fcnt", 32'(bus.frame_cnt), 32'd4);
    chk("t3_fly_lock", 32'(bus.locked), 32'h1);
    put(8'h00, 0);
    chk("t3_drop", 32'(bus.locked), 32'h0);
    put(8'h00, 0);
    v0 = nvld;
    payload(0);
    settle();
    chk("t3_quiet", 32'(nvld), 32'(v0));
    chk("t3_nerr", 32'(nerr), 32'(e0 + 3));
    hdr(0);
    payload(0);
    chk("t3_one_good", 32'(bus.locked), 32'h0);
    hdr(0);
    chk("t3_relock", 32'(bus.locked), 32'h1);
    payload(0);
    settle();
    chk("t3_fcnt", 32'(bus.frame_cnt), 32'd5);

    // 4: gapped input across two locked frames
    v0 = nvld;
    s0 = nsof;
    f0 = neof;
    hdr(1);
    payload(1);
    hdr(1);
    payload(1);
    settle();
    chk("t4_nvld", 32'(nvld - v0), 32'd248);
    chk("t4_nsof", 32'(nsof - s0), 32'd2);
    chk("t4_neof", 32'(neof - f0), 32'd2);
    chk("t4_late", 32'(late_vld), 32'd0);
    chk("t4_seq", 32'(seq_bad), 32'd0);
    chk("t4_fcnt", 32'(bus.frame_cnt), 32'd7);

    // 5b: header pattern inside locked payload
    pay[10] = 8'hEE;
    pay[11] = 8'h33;
    hdr(0);
    payload(0);
    pay[10] = 8'd10;
    pay[11] = 8'd11;
    hdr(0);
    payload(0);
    settle();
    chk("t5b_nerr", 32'(nerr), 32'(e0 + 3));
    chk("t5b_fcnt", 32'(bus.frame_cnt), 32'd9);
    chk("t5b_lock", 32'(bus.locked), 32'h1);
    chk("t5b_seq", 32'(seq_bad), 32'd0);

    // 6: asynchronous reset mid-payload
    hdr(0);
    for (int i = 0; i < 5; i++) put(pay[i], 0);
    chk("t6_pre_vld", 32'(bus.dout_vld), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("t6_vld", 32'(bus.dout_vld), 32'h0);
    chk("t6_lock", 32'(bus.locked), 32'h0);
    chk("t6_fcnt", 32'(bus.frame_cnt), 32'h0);
    chk("t6_dout", 32'(bus.dout), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 5a: false hit in hunt, then fresh two-header lock
    hdr(0);
    payload(0);
    put(8'hEE, 0);
    put(8'h00, 0);
    chk("t5a_err", 32'(bus.frame_err), 32'h1);
    chk("t5a_nolock", 32'(bus.locked), 32'h0);
    hdr(0);
    payload(0);
    chk("t6_one_good", 32'(bus.locked), 32'h0);
    hdr(0);
    chk("t6_relock", 32'(bus.locked), 32'h1);
    payload(0);
    settle();
    chk("t6_fcnt_after", 32'(bus.frame_cnt), 32'd1);

    // 7: wide words, 4-word header, immediate lock
    put2(16'hF0F0);
    put2(16'h1234);
    put2(16'hABCD);
    chk("t7_pre_lock", 32'(bus2.locked), 32'h0);
    put2(16'h5A5A);
    chk("t7_lock", 32'(bus2.locked), 32'h1);
    for (int i = 0; i < 8; i++) put2(16'hA000 + 16'(i));
    settle();
    chk("t7_nvld", 32'(nvld2), 32'd8);
    chk("t7_sof", 32'(sof2_dat), 32'hA000);
    chk("t7_eof", 32'(eof2_dat), 32'hA007);
    chk("t7_seq", 32'(seq2_bad), 32'd0);
    chk("t7_fcnt", 32'(bus2.frame_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
